// File: rtl/kernel_calc_bank.sv
// kernel_calc_bank: NUM_CH signed kernels applied to one shared pixel window.
// Four stages: product, sum, round (power-of-two divide), saturate.
// All channels share a single valid pipeline and a common en stall.

// One channel of the datapath: products, adder tree, rounding, clamp.
module kcb_lane #(
    parameter int IN_WIDTH      = 8,
    parameter int COEF_WIDTH    = 8,
    parameter int WIN           = 3,
    parameter int ACC_WIDTH     = 20,
    parameter int SHIFT         = 1,
    parameter int OUT_WIDTH     = 8,
    parameter int SIGNED_OUTPUT = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [WIN-1:0][IN_WIDTH:0]         pix,
    input  logic [WIN-1:0][COEF_WIDTH-1:0]     coef,
    output logic [OUT_WIDTH-1:0]               value,
    output logic                               sat
);
    localparam int PW = IN_WIDTH + 1 + COEF_WIDTH;

    // Clamp bounds, held at accumulator width so compares stay signed.
    localparam logic signed [ACC_WIDTH-1:0] SMAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SMIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] UMAX =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic [WIN-1:0][PW-1:0]      prod_d, prod_q;
    logic signed [ACC_WIDTH-1:0] sum_d, sum_q, rnd_d, rnd_q;
    logic [OUT_WIDTH-1:0]        val_d;
    logic                        sat_d;

    // Signed products; coef is read here, so a same-edge write is not yet seen.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < WIN; i++)
            prod_d[i] = PW'($signed(pix[i])) * PW'($signed(coef[i]));
    end

    // Sum of all taps, sign-extended into the headroom of ACC_WIDTH.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < WIN; i++)
            sum_d = sum_d + ACC_WIDTH'($signed(prod_q[i]));
    end

    // Round half toward +inf, then arithmetic divide by 2^SHIFT.
    if (SHIFT > 0) begin : g_rnd
        localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (SHIFT - 1);
        assign rnd_d = (sum_q + HALF) >>> SHIFT;
    end else begin : g_nornd
        assign rnd_d = sum_q;
    end

    // Clamp to the output range and flag any change.
    always_comb begin
        val_d = rnd_q[OUT_WIDTH-1:0];
        sat_d = 1'b0;
        if (SIGNED_OUTPUT != 0) begin
            if (rnd_q > SMAX) begin
                val_d = SMAX[OUT_WIDTH-1:0];
                sat_d = 1'b1;
            end else if (rnd_q < SMIN) begin
                val_d = SMIN[OUT_WIDTH-1:0];
                sat_d = 1'b1;
            end
        end else begin
            if (rnd_q > UMAX) begin
                val_d = UMAX[OUT_WIDTH-1:0];
                sat_d = 1'b1;
            end else if (rnd_q < 0) begin
                val_d = '0;
                sat_d = 1'b1;
            end
        end
    end

    // Pipeline registers S1..S4, frozen when en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            sum_q  <= '0;
            rnd_q  <= '0;
            value  <= '0;
            sat    <= 1'b0;
        end else if (en) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
            rnd_q  <= rnd_d;
            value  <= val_d;
            sat    <= sat_d;
        end
    end
endmodule

module kernel_calc_bank #(
    parameter int IN_WIDTH      = 8,
    parameter int KERNEL_WIDTH  = 1,
    parameter int KERNEL_HEIGHT = 3,
    parameter int NUM_CH        = 2,
    parameter int COEF_WIDTH    = 8,
    parameter int SHIFT         = 1,
    parameter int OUT_WIDTH     = 8,
    parameter int SIGNED_INPUT  = 1,
    parameter int SIGNED_OUTPUT = 1,
    localparam int WIN       = KERNEL_WIDTH * KERNEL_HEIGHT,
    localparam int ACC_WIDTH = IN_WIDTH + 1 + COEF_WIDTH + $clog2(WIN) + 1,
    localparam int NCOEF     = NUM_CH * WIN,
    localparam int AW        = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        valid_in,
    input  logic [IN_WIDTH*WIN-1:0]     values_in,
    input  logic                        coef_wr,
    input  logic [AW-1:0]               coef_addr,
    input  logic [COEF_WIDTH-1:0]       coef_data,
    output logic                        valid_out,
    output logic [OUT_WIDTH*NUM_CH-1:0] value_out,
    output logic [NUM_CH-1:0]           sat_out
);
    localparam int STAGES = 4;
    localparam logic [AW:0] NCOEF_W = (AW+1)'(NCOEF);

    logic [NCOEF-1:0][COEF_WIDTH-1:0] coef_q;
    logic [WIN-1:0][IN_WIDTH:0]       pix_ext;
    logic [STAGES:1]                  vld_pipe;

    // Coefficient file; writes ignore en and drop out-of-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coef_q <= '0;
        else if (coef_wr && ({1'b0, coef_addr} < NCOEF_W))
            coef_q[coef_addr] <= coef_data;
    end

    // Widen each pixel by one bit so unsigned pixels multiply as signed.
    for (genvar i = 0; i < WIN; i++) begin : g_pix
        assign pix_ext[i] = {(SIGNED_INPUT != 0) & values_in[i*IN_WIDTH + IN_WIDTH-1],
                             values_in[i*IN_WIDTH +: IN_WIDTH]};
    end

    // Valid shift register, moving in lockstep with the lane data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
    end

    assign valid_out = vld_pipe[STAGES];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        kcb_lane #(
            .IN_WIDTH      (IN_WIDTH),
            .COEF_WIDTH    (COEF_WIDTH),
            .WIN           (WIN),
            .ACC_WIDTH     (ACC_WIDTH),
            .SHIFT         (SHIFT),
            .OUT_WIDTH     (OUT_WIDTH),
            .SIGNED_OUTPUT (SIGNED_OUTPUT)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .pix   (pix_ext),
            .coef  (coef_q[c*WIN +: WIN]),
            .value (value_out[c*OUT_WIDTH +: OUT_WIDTH]),
            .sat   (sat_out[c])
        );
    end
endmodule

// File: tb/tb_kernel_calc_bank.sv
// Directed bench for kernel_calc_bank: a signed-output instance and an
// unsigned-output instance share all inputs.
module tb_kernel_calc_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        valid_in = 1'b0;
    logic [23:0] values_in = '0;
    logic        coef_wr = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        valid_out, u_valid_out;
    logic [15:0] value_out, u_value_out;
    logic [1:0]  sat_out, u_sat_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kernel_calc_bank dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .values_in(values_in),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .valid_out(valid_out), .value_out(value_out), .sat_out(sat_out)
    );

    kernel_calc_bank #(.SIGNED_OUTPUT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .values_in(values_in),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .valid_out(u_valid_out), .value_out(u_value_out), .sat_out(u_sat_out)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int s_ch(input int c);
        return int'($signed(value_out[c*8 +: 8]));
    endfunction

    function automatic int u_ch(input int c);
        return int'(u_value_out[c*8 +: 8]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic win(input int a, input int b, input int c);
        values_in = {8'(c), 8'(b), 8'(a)};
    endtask

    task automatic wr(input int addr, input int data);
        coef_wr   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 8'(data);
        step();
        coef_wr   = 1'b0;
    endtask

    // One window in, then three bubbles; valid must show up only after edge 4.
    task automatic run_win(input string tag, input int a, input int b, input int c);
        en = 1'b1;
        valid_in = 1'b1;
        win(a, b, c);
        step();
        valid_in = 1'b0;
        step();
        step();
        chk({tag, "_early"}, valid_out, 0);
        step();
        chk({tag, "_vld"}, valid_out, 1);
    endtask

    // One stall-test cycle: drive, clock, then check valid and (if valid) both channels.
    task automatic cyc(input string tag, input logic e, input logic v, input int k,
                       input int evld, input int e0, input int e1);
        en = e;
        valid_in = v;
        win(10 + 2*k, k, 0);
        step();
        chk({tag, "_vld"}, valid_out, evld);
        if (evld == 1) begin
            chk({tag, "_c0"}, s_ch(0), e0);
            chk({tag, "_c1"}, s_ch(1), e1);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_vld", valid_out, 0);
        chk("rst_val", int'(value_out), 0);
        chk("rst_sat", int'(sat_out), 0);
        rst_n = 1'b1;
        step();

        // Gradient: ch0 {-1,0,1}, ch1 {1,2,1}
        wr(0, -1); wr(1, 0); wr(2, 1);
        wr(3, 1);  wr(4, 2); wr(5, 1);
        run_win("grad", 10, 50, 30);
        chk("grad_c0", s_ch(0), 10);
        chk("grad_c1", s_ch(1), 70);
        chk("grad_sat", int'(sat_out), 0);
        chk("grad_u_c0", u_ch(0), 10);
        chk("grad_u_c1", u_ch(1), 70);

        // Rounding of negatives: ch0 {1,0,0}
        wr(0, 1); wr(2, 0);
        run_win("rnd_m3", -3, 0, 0);
        chk("rnd_m3_c0", s_ch(0), -1);
        chk("rnd_m3_c1", s_ch(1), -1);
        chk("rnd_m3_u", u_ch(0), 0);
        chk("rnd_m3_usat", int'(u_sat_out[0]), 1);
        run_win("rnd_m4", -4, 0, 0);
        chk("rnd_m4_c0", s_ch(0), -2);
        run_win("rnd_p3", 3, 0, 0);
        chk("rnd_p3_c0", s_ch(0), 2);
        chk("rnd_p3_sat", int'(sat_out), 0);

        // Stall and bubble: W0 W1 bubble W2, 3 frozen cycles, W3 W4
        cyc("st1", 1'b1, 1'b1, 0, 0, 0, 0);
        cyc("st2", 1'b1, 1'b1, 1, 0, 0, 0);
        cyc("st3", 1'b1, 1'b0, 9, 0, 0, 0);
        cyc("st4", 1'b1, 1'b1, 2, 1, 5, 5);
        cyc("frz1", 1'b0, 1'b1, 7, 1, 5, 5);
        cyc("frz2", 1'b0, 1'b0, 7, 1, 5, 5);
        cyc("frz3", 1'b0, 1'b1, 7, 1, 5, 5);
        cyc("st5", 1'b1, 1'b1, 3, 1, 6, 7);
        cyc("st6", 1'b1, 1'b1, 4, 0, 0, 0);
        cyc("st7", 1'b1, 1'b0, 0, 1, 7, 9);
        cyc("st8", 1'b1, 1'b0, 0, 1, 8, 11);
        cyc("st9", 1'b1, 1'b0, 0, 1, 9, 13);
        cyc("st10", 1'b1, 1'b0, 0, 0, 0, 0);

        // Saturation, positive then negative
        wr(0, 127); wr(1, 127); wr(2, 127);
        run_win("satp", 127, 127, 127);
        chk("satp_c0", s_ch(0), 127);
        chk("satp_s0", int'(sat_out[0]), 1);
        chk("satp_c1", s_ch(1), 127);
        chk("satp_s1", int'(sat_out[1]), 1);
        chk("satp_u_c0", u_ch(0), 255);
        chk("satp_u_s0", int'(u_sat_out[0]), 1);
        chk("satp_u_c1", u_ch(1), 254);
        chk("satp_u_s1", int'(u_sat_out[1]), 0);
        wr(0, -128); wr(1, -128); wr(2, -128);
        run_win("satn", 127, 127, 127);
        chk("satn_c0", s_ch(0), -128);
        chk("satn_s0", int'(sat_out[0]), 1);
        chk("satn_u_c0", u_ch(0), 0);
        chk("satn_u_s0", int'(u_sat_out[0]), 1);

        // Coefficient hazard: ch0 {0,0,1}, tap2 -> 3 on window A's edge
        wr(0, 0); wr(1, 0); wr(2, 1);
        en = 1'b1;
        valid_in = 1'b1;
        win(0, 0, 4);
        coef_wr = 1'b1; coef_addr = 3'd2; coef_data = 8'd3;
        step();
        coef_wr = 1'b0;
        step();
        valid_in = 1'b0;
        step();
        step();
        chk("hzA_vld", valid_out, 1);
        chk("hzA_c0", s_ch(0), 2);
        chk("hzA_c1", s_ch(1), 2);
        step();
        chk("hzB_vld", valid_out, 1);
        chk("hzB_c0", s_ch(0), 6);
        chk("hzB_c1", s_ch(1), 2);
        step();

        // Reset with three windows in flight
        valid_in = 1'b1;
        win(20, 20, 20);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", valid_out, 0);
        chk("mrst_val", int'(value_out), 0);
        chk("mrst_sat", int'(sat_out), 0);
        valid_in = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mrst_drain%0d", i), valid_out, 0);
        end
        run_win("post", 10, 50, 30);
        chk("post_c0", s_ch(0), 0);
        chk("post_c1", s_ch(1), 0);
        chk("post_sat", int'(sat_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
